// File: rtl/bn_pkg.sv
// Shared types and default table layout for the best-neighbor selector.
// The default base addresses match the firmware memory map.
package bn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_CNT,
    RD_ID,
    RD_HOP,
    RD_Q,
    CMP,
    WR_ID,
    WR_HOP,
    WR_Q,
    WR_CNT,
    DONE
  } bn_state_e;

  localparam int MODE_Q_ONLY = 0;
  localparam int MODE_Q_HOP  = 1;

  localparam int unsigned NCNT_BASE_DEF = 32'h2C4;
  localparam int unsigned NID_BASE_DEF  = 32'h072;
  localparam int unsigned NHOP_BASE_DEF = 32'h132;
  localparam int unsigned NQ_BASE_DEF   = 32'h172;
  localparam int unsigned BID_BASE_DEF  = 32'h2F8;
  localparam int unsigned BHOP_BASE_DEF = 32'h308;
  localparam int unsigned BQ_BASE_DEF   = 32'h318;
  localparam int unsigned BCNT_BASE_DEF = 32'h2B8;

endpackage

// File: rtl/best_tracker.sv
// Tracks the single best selected neighbor: highest Q, then lowest hop.
// The first entry seen wins a full tie, and outputs stay 0 until something is offered.
module best_tracker #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  clear_i,
  input  logic                  update_i,
  input  logic [WORD_WIDTH-1:0] candId_i,
  input  logic [WORD_WIDTH-1:0] candHop_i,
  input  logic [WORD_WIDTH-1:0] candQ_i,
  output logic [WORD_WIDTH-1:0] bestId_o,
  output logic [WORD_WIDTH-1:0] bestHop_o,
  output logic [WORD_WIDTH-1:0] bestQ_o
);

  logic                  have_q;
  logic [WORD_WIDTH-1:0] id_q;
  logic [WORD_WIDTH-1:0] hop_q;
  logic [WORD_WIDTH-1:0] q_q;
  logic                  better_d;

  // The first candidate is always taken so a Q of 0 can still be reported.
  always_comb begin
    better_d = !have_q || (candQ_i > q_q) || ((candQ_i == q_q) && (candHop_i < hop_q));
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      have_q <= 1'b0;
      id_q   <= '0;
      hop_q  <= '0;
      q_q    <= '0;
    end else if (clear_i) begin
      have_q <= 1'b0;
      id_q   <= '0;
      hop_q  <= '0;
      q_q    <= '0;
    end else if (update_i && better_d) begin
      have_q <= 1'b1;
      id_q   <= candId_i;
      hop_q  <= candHop_i;
      q_q    <= candQ_i;
    end
  end

  assign bestId_o  = id_q;
  assign bestHop_o = hop_q;
  assign bestQ_o   = q_q;

endmodule

// File: rtl/best_neighbor_select.sv
// Scans the neighbor table in memory, copies qualifying entries into the best
// table, writes the resulting count and reports the single best neighbor.
module best_neighbor_select
  import bn_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_NEIGH  = 32,
  parameter int MAX_BEST   = 8,
  parameter int MODE       = MODE_Q_ONLY,
  parameter logic [ADDR_WIDTH-1:0] NCNT_BASE = ADDR_WIDTH'(NCNT_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] NID_BASE  = ADDR_WIDTH'(NID_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] NHOP_BASE = ADDR_WIDTH'(NHOP_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] NQ_BASE   = ADDR_WIDTH'(NQ_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] BID_BASE  = ADDR_WIDTH'(BID_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] BHOP_BASE = ADDR_WIDTH'(BHOP_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] BQ_BASE   = ADDR_WIDTH'(BQ_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] BCNT_BASE = ADDR_WIDTH'(BCNT_BASE_DEF)
) (
  input  logic                             clock,
  input  logic                             nrst,
  input  logic                             en,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            data_in,
  input  logic [WORD_WIDTH-1:0]            mybestQ,
  input  logic [WORD_WIDTH-1:0]            mybestH,
  output logic [ADDR_WIDTH-1:0]            address,
  output logic [WORD_WIDTH-1:0]            data_out,
  output logic                             wr_en,
  output logic                             done,
  output logic [$clog2(MAX_BEST+1)-1:0]    best_count,
  output logic                             overflow,
  output logic [WORD_WIDTH-1:0]            besthop,
  output logic [WORD_WIDTH-1:0]            bestneighborID,
  output logic [WORD_WIDTH-1:0]            bestQValue
);

  localparam int NW  = $clog2(MAX_NEIGH + 1);
  localparam int BCW = $clog2(MAX_BEST + 1);

  bn_state_e             state_q;
  logic [NW-1:0]         nIdx_q;
  logic [NW-1:0]         nCnt_q;
  logic [WORD_WIDTH-1:0] entId_q;
  logic [WORD_WIDTH-1:0] entHop_q;
  logic [WORD_WIDTH-1:0] entQ_q;
  logic [BCW-1:0]        bestCnt_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] dataOut_q;
  logic                  wrEn_q;
  logic                  done_q;

  logic                  selected;
  logic                  room;
  logic                  writeEntry;
  logic                  advance;
  logic                  lastEntry;
  logic [NW-1:0]         nNext;
  logic [NW-1:0]         nCntLoad;
  logic [BCW-1:0]        bcNext;
  logic [BCW-1:0]        cntForWrite;

  // Word tables are byte addressed; wrap-around is intentional.
  function automatic logic [ADDR_WIDTH-1:0] tblAddr(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [31:0] idx);
    return base + ADDR_WIDTH'(idx << 1);
  endfunction

  always_comb begin
    selected    = (entQ_q >= mybestQ) && ((MODE == MODE_Q_ONLY) || (entHop_q <= mybestH));
    room        = bestCnt_q < BCW'(MAX_BEST);
    writeEntry  = (state_q == CMP) && selected && room;
    advance     = ((state_q == CMP) && !writeEntry) || (state_q == WR_Q);
    nNext       = nIdx_q + NW'(1);
    lastEntry   = (nNext == nCnt_q);
    bcNext      = bestCnt_q + BCW'(1);
    cntForWrite = (state_q == WR_Q) ? bcNext : bestCnt_q;
    nCntLoad    = (data_in > WORD_WIDTH'(MAX_NEIGH)) ? NW'(MAX_NEIGH) : NW'(data_in);
  end

  // Address is registered, so each read state consumes the word requested by the previous one.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      nIdx_q     <= '0;
      nCnt_q     <= '0;
      entId_q    <= '0;
      entHop_q   <= '0;
      entQ_q     <= '0;
      bestCnt_q  <= '0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      dataOut_q  <= '0;
      wrEn_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wrEn_q <= 1'b0;
      done_q <= 1'b0;
      if ((state_q != IDLE) && !en) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (en && start) begin
              nIdx_q     <= '0;
              bestCnt_q  <= '0;
              overflow_q <= 1'b0;
              addr_q     <= NCNT_BASE;
              state_q    <= RD_CNT;
            end
          end
          RD_CNT: begin
            nCnt_q <= nCntLoad;
            if (nCntLoad == '0) begin
              addr_q    <= BCNT_BASE;
              dataOut_q <= WORD_WIDTH'(cntForWrite);
              wrEn_q    <= 1'b1;
              state_q   <= WR_CNT;
            end else begin
              addr_q  <= tblAddr(NID_BASE, 32'(nIdx_q));
              state_q <= RD_ID;
            end
          end
          RD_ID: begin
            entId_q <= data_in;
            addr_q  <= tblAddr(NHOP_BASE, 32'(nIdx_q));
            state_q <= RD_HOP;
          end
          RD_HOP: begin
            entHop_q <= data_in;
            addr_q   <= tblAddr(NQ_BASE, 32'(nIdx_q));
            state_q  <= RD_Q;
          end
          RD_Q: begin
            entQ_q  <= data_in;
            state_q <= CMP;
          end
          CMP: begin
            if (writeEntry) begin
              addr_q    <= tblAddr(BID_BASE, 32'(bestCnt_q));
              dataOut_q <= entId_q;
              wrEn_q    <= 1'b1;
              state_q   <= WR_ID;
            end else if (selected) begin
              overflow_q <= 1'b1;
            end
          end
          WR_ID: begin
            addr_q    <= tblAddr(BHOP_BASE, 32'(bestCnt_q));
            dataOut_q <= entHop_q;
            wrEn_q    <= 1'b1;
            state_q   <= WR_HOP;
          end
          WR_HOP: begin
            addr_q    <= tblAddr(BQ_BASE, 32'(bestCnt_q));
            dataOut_q <= entQ_q;
            wrEn_q    <= 1'b1;
            state_q   <= WR_Q;
          end
          WR_Q: begin
            bestCnt_q <= bcNext;
          end
          WR_CNT: begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase

        // Shared exit from CMP (no write) and WR_Q: next entry or the final count write.
        if (advance) begin
          nIdx_q <= nNext;
          if (lastEntry) begin
            addr_q    <= BCNT_BASE;
            dataOut_q <= WORD_WIDTH'(cntForWrite);
            wrEn_q    <= 1'b1;
            state_q   <= WR_CNT;
          end else begin
            addr_q  <= tblAddr(NID_BASE, 32'(nNext));
            state_q <= RD_ID;
          end
        end
      end
    end
  end

  best_tracker #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_best_tracker (
    .clock     (clock),
    .nrst      (nrst),
    .clear_i   ((state_q == IDLE) && en && start),
    .update_i  ((state_q == CMP) && en && selected),
    .candId_i  (entId_q),
    .candHop_i (entHop_q),
    .candQ_i   (entQ_q),
    .bestId_o  (bestneighborID),
    .bestHop_o (besthop),
    .bestQ_o   (bestQValue)
  );

  assign address    = addr_q;
  assign data_out   = dataOut_q;
  assign wr_en      = wrEn_q;
  assign done       = done_q;
  assign best_count = bestCnt_q;
  assign overflow   = overflow_q;

endmodule
